// File: rtl/engine_sequencer_pkg.sv
// Shared types and helpers for the engine sequencer.
// State encoding, unity gain and the saturating clamp.
package engine_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAIN,
    S_TICK,
    S_SETTLE,
    S_WAIT,
    S_MIX,
    S_OUTPUT
  } state_t;

  localparam int GAIN_SHIFT = 5;
  localparam int UNITY_GAIN = 1 << GAIN_SHIFT;

  function automatic int unity_gain(input int shift);
    return 1 << shift;
  endfunction

  // Clamp a sign-extended value into a w-bit signed range.
  function automatic logic signed [63:0] sat_wide(
    input logic signed [63:0] v,
    input int unsigned w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/engine_sequencer_gain_sat_mul.sv
// Signed fixed-point gain: multiply, arithmetic shift, saturate.
// Operand a may be wider than the result (mix sums).
module gain_sat_mul
  import engine_sequencer_pkg::*;
#(
  parameter int a_width    = 16,
  parameter int data_width = 16,
  parameter int gain_shift = 5
) (
  input  logic signed [a_width-1:0]    a,
  input  logic signed [data_width-1:0] gain,
  output logic signed [data_width-1:0] y
);

  localparam int pw = a_width + data_width;

  logic signed [pw-1:0] prod;
  logic signed [pw-1:0] shifted;

  assign prod    = pw'(a) * pw'(gain);
  assign shifted = prod >>> gain_shift;
  assign y       = data_width'(sat_wide(64'(shifted), data_width));

endmodule

// File: rtl/engine_sequencer.sv
// Frame sequencer: gains each lane, ticks the pipelines,
// waits for them, mixes results and emits the frame.
module engine_sequencer
  import engine_sequencer_pkg::*;
#(
  parameter int data_width     = 16,
  parameter int n_lanes        = 2,
  parameter int n_pipelines    = 2,
  parameter int gain_shift     = GAIN_SHIFT,
  parameter int timeout_cycles = 4096
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [n_lanes*data_width-1:0]     in_frame,
  input  logic                              sample_ready,
  output logic                              ready,
  output logic [n_lanes*data_width-1:0]     out_frame,
  output logic                              out_valid,
  output logic [data_width-1:0]             pipe_sample,
  output logic [((n_lanes > 1) ? $clog2(n_lanes) : 1)-1:0] pipe_lane,
  output logic                              pipe_tick,
  input  logic [n_pipelines-1:0]            pipe_ready,
  input  logic [n_pipelines*data_width-1:0] pipe_out,
  input  logic [n_pipelines-1:0]            pipe_enable,
  input  logic [data_width-1:0]             ctrl_data,
  input  logic                              set_input_gain,
  input  logic                              set_output_gain,
  output logic                              timeout_err,
  output logic [15:0]                       overrun_count,
  output logic [15:0]                       timeout_count,
  output logic [31:0]                       frame_count
);

  localparam int lane_w = (n_lanes > 1) ? $clog2(n_lanes) : 1;
  localparam int sum_w  = data_width + $clog2(n_pipelines) + 1;
  localparam logic [data_width-1:0] unity =
    data_width'(unity_gain(gain_shift));

  state_t                         state;
  logic [lane_w-1:0]              lane;
  logic [n_lanes*data_width-1:0]  frame_q;
  logic signed [data_width-1:0]   in_gain;
  logic signed [data_width-1:0]   out_gain;
  logic signed [data_width-1:0]   lane_sample;
  logic signed [data_width-1:0]   gained;
  logic signed [data_width-1:0]   mixed;
  logic signed [sum_w-1:0]        sum;
  logic [31:0]                    wait_cnt;
  logic                           timed_out;
  logic                           all_ready;
  logic                           last_lane;

  assign lane_sample = frame_q[int'(lane)*data_width +: data_width];
  assign all_ready   = &(pipe_ready | ~pipe_enable);
  assign last_lane   = (int'(lane) == n_lanes - 1);

  // Disabled pipelines contribute nothing to the mix.
  always_comb begin
    sum = '0;
    for (int p = 0; p < n_pipelines; p++) begin
      if (pipe_enable[p])
        sum = sum + sum_w'(signed'(pipe_out[p*data_width +: data_width]));
    end
  end

  gain_sat_mul #(
    .a_width   (data_width),
    .data_width(data_width),
    .gain_shift(gain_shift)
  ) u_in_gain (
    .a   (lane_sample),
    .gain(in_gain),
    .y   (gained)
  );

  gain_sat_mul #(
    .a_width   (sum_w),
    .data_width(data_width),
    .gain_shift(gain_shift)
  ) u_out_gain (
    .a   (sum),
    .gain(out_gain),
    .y   (mixed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      ready         <= 1'b1;
      out_valid     <= 1'b0;
      pipe_tick     <= 1'b0;
      out_frame     <= '0;
      pipe_sample   <= '0;
      pipe_lane     <= '0;
      lane          <= '0;
      frame_q       <= '0;
      in_gain       <= unity;
      out_gain      <= unity;
      wait_cnt      <= '0;
      timed_out     <= 1'b0;
      timeout_err   <= 1'b0;
      overrun_count <= '0;
      timeout_count <= '0;
      frame_count   <= '0;
    end else begin
      out_valid <= 1'b0;
      pipe_tick <= 1'b0;
      if (set_input_gain)  in_gain  <= ctrl_data;
      if (set_output_gain) out_gain <= ctrl_data;
      if (sample_ready && state != S_IDLE &&
          overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;
      unique case (state)
        S_IDLE: begin
          if (sample_ready) begin
            frame_q <= in_frame;
            lane    <= '0;
            ready   <= 1'b0;
            state   <= S_GAIN;
          end
        end
        S_GAIN: begin
          pipe_sample <= gained;
          pipe_lane   <= lane;
          pipe_tick   <= 1'b1;
          state       <= S_TICK;
        end
        S_TICK: state <= S_SETTLE;
        S_SETTLE: begin
          wait_cnt  <= '0;
          timed_out <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (all_ready) begin
            state <= S_MIX;
          end else if (wait_cnt == 32'(timeout_cycles - 1)) begin
            timed_out   <= 1'b1;
            timeout_err <= 1'b1;
            if (timeout_count != 16'hFFFF)
              timeout_count <= timeout_count + 16'd1;
            state <= S_MIX;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_MIX: begin
          out_frame[int'(lane)*data_width +: data_width] <=
            timed_out ? '0 : mixed;
          if (last_lane) begin
            state <= S_OUTPUT;
          end else begin
            lane  <= lane + 1'b1;
            state <= S_GAIN;
          end
        end
        S_OUTPUT: begin
          out_valid   <= 1'b1;
          frame_count <= frame_count + 32'd1;
          ready       <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_engine_sequencer.sv
// Self-checking bench for engine_sequencer: directed cases
// plus random frames against a behavioural lane model.
module tb_engine_sequencer;
  import engine_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_frame = '0;
  logic        sample_ready = 1'b0;
  logic        ready;
  logic [31:0] out_frame;
  logic        out_valid;
  logic [15:0] pipe_sample;
  logic [0:0]  pipe_lane;
  logic        pipe_tick;
  logic [1:0]  pipe_ready;
  logic [31:0] pipe_out;
  logic [1:0]  pipe_enable;
  logic [15:0] ctrl_data = '0;
  logic        set_input_gain = 1'b0;
  logic        set_output_gain = 1'b0;
  logic        timeout_err;
  logic [15:0] overrun_count;
  logic [15:0] timeout_count;
  logic [31:0] frame_count;

  int compared = 0;
  int mismatched = 0;

  int          lat = 1;
  int          stuck_pipe = -1;
  int          stuck_lane = -1;
  bit          use_sample = 1'b0;
  logic [15:0] padd [2];
  logic [1:0]  en_lane [2];
  logic [15:0] pend [2];
  int          cnt [2];
  logic [15:0] seen [$];
  logic [15:0] m_ig;
  logic [15:0] m_og;

  always #5 clk = ~clk;

  engine_sequencer dut (
    .clk            (clk),
    .reset          (rst_n),
    .in_frame       (in_frame),
    .sample_ready   (sample_ready),
    .ready          (ready),
    .out_frame      (out_frame),
    .out_valid      (out_valid),
    .pipe_sample    (pipe_sample),
    .pipe_lane      (pipe_lane),
    .pipe_tick      (pipe_tick),
    .pipe_ready     (pipe_ready),
    .pipe_out       (pipe_out),
    .pipe_enable    (pipe_enable),
    .ctrl_data      (ctrl_data),
    .set_input_gain (set_input_gain),
    .set_output_gain(set_output_gain),
    .timeout_err    (timeout_err),
    .overrun_count  (overrun_count),
    .timeout_count  (timeout_count),
    .frame_count    (frame_count)
  );

  // Pipeline responder: result = (sample or 0) + addend, ready lat cycles after tick.
  always @(posedge clk) begin
    if (!rst_n) begin
      pipe_ready  <= 2'b00;
      pipe_out    <= '0;
      pipe_enable <= 2'b11;
      cnt[0]      <= 0;
      cnt[1]      <= 0;
    end else if (pipe_tick) begin
      seen.push_back(pipe_sample);
      pipe_enable <= en_lane[pipe_lane];
      for (int p = 0; p < 2; p++) begin
        pipe_ready[p] <= 1'b0;
        pend[p] <= (use_sample ? pipe_sample : 16'h0) + padd[p];
        cnt[p] <= (p == stuck_pipe && int'(pipe_lane) == stuck_lane) ? 0 : lat;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (cnt[p] > 0) begin
          cnt[p] <= cnt[p] - 1;
          if (cnt[p] == 1) begin
            pipe_ready[p] <= 1'b1;
            pipe_out[p*16 +: 16] <= pend[p];
          end
        end
      end
    end
  end

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [15:0] scale(input longint x, input logic [15:0] g);
    longint p;
    p = x * longint'($signed(g));
    return sat16(p >>> GAIN_SHIFT);
  endfunction

  function automatic logic [15:0] model_lane(
    input logic [15:0] s, input logic [15:0] ig, input logic [15:0] og,
    input logic [1:0] en, input bit use_s,
    input logic [15:0] pa0, input logic [15:0] pa1
  );
    logic [15:0] g;
    logic [15:0] o0;
    logic [15:0] o1;
    longint sum;
    g = scale(longint'($signed(s)), ig);
    o0 = (use_s ? g : 16'h0) + pa0;
    o1 = (use_s ? g : 16'h0) + pa1;
    sum = 0;
    if (en[0]) sum += longint'($signed(o0));
    if (en[1]) sum += longint'($signed(o1));
    return scale(sum, og);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) check("idle_wait", ready, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic run_frame(input logic [31:0] f, output int n);
    wait_idle();
    seen.delete();
    in_frame = f;
    sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    wait_valid(n);
  endtask

  task automatic set_gain(input bit gi, input bit go, input logic [15:0] v);
    @(negedge clk);
    ctrl_data = v;
    set_input_gain = gi;
    set_output_gain = go;
    @(negedge clk);
    set_input_gain = 1'b0;
    set_output_gain = 1'b0;
    if (gi) m_ig = v;
    if (go) m_og = v;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    bit saw;
    logic [31:0] f;
    logic [31:0] fc;
    logic [15:0] e0;
    logic [15:0] e1;

    padd[0] = 16'h0100;
    padd[1] = 16'h0200;
    en_lane[0] = 2'b11;
    en_lane[1] = 2'b11;
    m_ig = 16'(UNITY_GAIN);
    m_og = 16'(UNITY_GAIN);

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_pipe_tick", pipe_tick, 0);
    check("rst_out_frame", out_frame, 0);
    check("rst_pipe_sample", pipe_sample, 0);
    check("rst_pipe_lane", pipe_lane, 0);
    check("rst_overrun", overrun_count, 0);
    check("rst_timeout_cnt", timeout_count, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_frame_count", frame_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unity gains, fixed pipeline results.
    use_sample = 1'b0;
    run_frame(32'h0020_0010, n);
    check("basic_latency", n, 11);
    check("basic_out", out_frame, 32'h0300_0300);
    check("basic_seen_n", seen.size(), 2);
    check("basic_seen0", seen[0], 16'h0010);
    check("basic_seen1", seen[1], 16'h0020);
    check("basic_fc", frame_count, 1);
    fc = 1;

    // Saturation on both gain stages.
    set_gain(1, 0, 16'h0040);
    use_sample = 1'b1;
    padd[0] = 16'h0;
    padd[1] = 16'h0;
    run_frame(32'h9000_7000, n);
    check("sat_seen0", seen[0], 16'h7FFF);
    check("sat_seen1", seen[1], 16'h8000);
    check("sat_out", out_frame, 32'h8000_7FFF);
    fc++;

    for (int i = 0; i < 20; i++) begin
      en_lane[0] = 2'($urandom_range(0, 3));
      en_lane[1] = 2'($urandom_range(0, 3));
      padd[0] = 16'($urandom);
      padd[1] = 16'($urandom);
      if (i % 5 == 0) begin
        set_gain(1, 1, 16'($urandom_range(0, 255)) - 16'd128);
      end else begin
        set_gain(1, 0, 16'($urandom_range(0, 255)) - 16'd128);
        set_gain(0, 1, 16'($urandom_range(0, 255)) - 16'd128);
      end
      f = $urandom;
      run_frame(f, n);
      fc++;
      e0 = model_lane(f[15:0], m_ig, m_og, en_lane[0], 1, padd[0], padd[1]);
      e1 = model_lane(f[31:16], m_ig, m_og, en_lane[1], 1, padd[0], padd[1]);
      check($sformatf("rnd%0d_latency", i), n, 11);
      check($sformatf("rnd%0d_lane0", i), out_frame[15:0], e0);
      check($sformatf("rnd%0d_lane1", i), out_frame[31:16], e1);
      check($sformatf("rnd%0d_seen_n", i), seen.size(), 2);
      if (seen.size() == 2) begin
        check($sformatf("rnd%0d_seen0", i), seen[0],
              scale(longint'($signed(f[15:0])), m_ig));
        check($sformatf("rnd%0d_seen1", i), seen[1],
              scale(longint'($signed(f[31:16])), m_ig));
      end
      check($sformatf("rnd%0d_fc", i), frame_count, fc);
    end
    check("rnd_no_overrun", overrun_count, 0);

    // Overrun pulses while waiting on slow pipelines.
    set_gain(1, 1, 16'(UNITY_GAIN));
    en_lane[0] = 2'b11;
    en_lane[1] = 2'b11;
    padd[0] = 16'h0011;
    padd[1] = 16'h0022;
    lat = 8;
    f = 32'h0200_0100;
    wait_idle();
    in_frame = f;
    sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    k = 0;
    while (pipe_tick !== 1'b1 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(posedge clk);
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      sample_ready = 1'b1;
      in_frame = $urandom;
      @(negedge clk);
      sample_ready = 1'b0;
    end
    wait_valid(n);
    fc++;
    e0 = model_lane(f[15:0], m_ig, m_og, 2'b11, 1, padd[0], padd[1]);
    e1 = model_lane(f[31:16], m_ig, m_og, 2'b11, 1, padd[0], padd[1]);
    check("ovr_lane0", out_frame[15:0], e0);
    check("ovr_lane1", out_frame[31:16], e1);
    check("ovr_count", overrun_count, 3);
    check("ovr_fc", frame_count, fc);

    // Frame counter wrap.
    lat = 1;
    wait_idle();
    force dut.frame_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.frame_count;
    run_frame(32'h0001_0001, n);
    check("wrap_fc", frame_count, 0);

    // Pipeline 1 stuck during lane 0.
    use_sample = 1'b0;
    padd[0] = 16'h0123;
    padd[1] = 16'h0456;
    stuck_pipe = 1;
    stuck_lane = 0;
    en_lane[0] = 2'b01;
    en_lane[1] = 2'b01;
    run_frame(32'h1111_2222, n);
    check("tmo_off_out", out_frame, 32'h0123_0123);
    check("tmo_off_err", timeout_err, 0);
    check("tmo_off_cnt", timeout_count, 0);
    en_lane[0] = 2'b11;
    en_lane[1] = 2'b11;
    run_frame(32'h1111_2222, n);
    check("tmo_on_out", out_frame, 32'h0579_0000);
    check("tmo_on_err", timeout_err, 1);
    check("tmo_on_cnt", timeout_count, 1);
    stuck_pipe = -1;
    stuck_lane = -1;

    // Reset in the middle of lane 1.
    lat = 8;
    use_sample = 1'b1;
    wait_idle();
    in_frame = 32'h0400_0300;
    sample_ready = 1'b1;
    @(posedge clk);
    #1 sample_ready = 1'b0;
    k = 0;
    while (!(pipe_tick === 1'b1 && pipe_lane === 1'b1) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_lane1_tick", pipe_lane, 1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_tick", pipe_tick, 0);
    check("mid_rst_frame", out_frame, 0);
    check("mid_rst_fc", frame_count, 0);
    check("mid_rst_tmo_err", timeout_err, 0);
    check("mid_rst_tmo_cnt", timeout_count, 0);
    check("mid_rst_ovr", overrun_count, 0);
    m_ig = 16'(UNITY_GAIN);
    m_og = 16'(UNITY_GAIN);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) saw = 1'b1;
    end
    check("mid_rst_no_valid", saw, 0);

    lat = 1;
    padd[0] = 16'($urandom);
    padd[1] = 16'($urandom);
    f = $urandom;
    run_frame(f, n);
    e0 = model_lane(f[15:0], m_ig, m_og, 2'b11, 1, padd[0], padd[1]);
    e1 = model_lane(f[31:16], m_ig, m_og, 2'b11, 1, padd[0], padd[1]);
    check("post_rst_latency", n, 11);
    check("post_rst_lane0", out_frame[15:0], e0);
    check("post_rst_lane1", out_frame[31:16], e1);
    check("post_rst_fc", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/engine_sequencer.md
ENGINE_SEQUENCER -- requirements
Module: engine_sequencer

Interface
REQ-001 Parameters SHALL be:
- data_width, 16, sample width (signed)
- n_lanes, 2, audio channels per frame
- n_pipelines, 2, pipelines sequenced in parallel
- gain_shift, 5, gain fraction bits
- timeout_cycles, 4096, max wait for pipeline ready
REQ-002 Ports SHALL be:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low
- in_frame  in  n_lanes*data_width  lane k at bits [k*data_width +: data_width]
- sample_ready  in  1  frame-valid pulse
- ready  out  1  idle, frame accepted next cycle
- out_frame  out  n_lanes*data_width  mixed frame
- out_valid  out  1  one-cycle pulse, out_frame valid
- pipe_sample  out  data_width  gained lane sample to pipelines
- pipe_lane  out  clog2(n_lanes) (min 1)  lane index being processed
- pipe_tick  out  1  one-cycle start pulse to all pipelines
- pipe_ready  in  n_pipelines  per-pipeline done
- pipe_out  in  n_pipelines*data_width  per-pipeline result
- pipe_enable  in  n_pipelines  mask; disabled pipelines ignored, contribute 0
- ctrl_data  in  data_width  gain value
- set_input_gain, set_output_gain  in  1  load pulses
- timeout_err  out  1  sticky until reset
- overrun_count, timeout_count  out  16  saturating counters
- frame_count  out  32  wrapping frame counter

Function
REQ-003 States SHALL be IDLE, GAIN, TICK, SETTLE, WAIT, MIX, OUTPUT.
REQ-004 IDLE: ready=1; on sample_ready latch in_frame, lane=0, go GAIN, ready=0 next cycle.
REQ-005 GAIN: pipe_sample <= sat((lane_sample * input_gain) >>> gain_shift), product 2*data_width wide, arithmetic shift, saturate to data_width; go TICK.
REQ-006 TICK: pipe_tick=1 exactly one cycle; go SETTLE; SETTLE lasts one cycle, then WAIT.
REQ-007 WAIT: exit to MIX when every pipe_ready bit with pipe_enable=1 is high; pipe_enable=0 everywhere exits next cycle.
REQ-008 WAIT exceeding timeout_cycles cycles SHALL set timeout_err, increment timeout_count, force lane result 0, go MIX.
REQ-009 MIX: sum enabled pipe_out in data_width+clog2(n_pipelines)+1 bits, multiply by output_gain, >>> gain_shift, saturate; store into out_frame lane; lane<n_lanes-1 -> lane+1, GAIN; else OUTPUT.
REQ-010 OUTPUT: out_valid=1 one cycle, frame_count+1 (wraps 2^32), go IDLE; out_frame holds until next OUTPUT.
REQ-011 Latency, all pipelines ready in SETTLE+1: 1+5*n_lanes cycles sample_ready to out_valid (n_lanes=2: 11).
REQ-012 sample_ready outside IDLE SHALL drop the frame and increment overrun_count (saturate 0xFFFF).
REQ-013 Gain pulses SHALL be accepted in any state, taking effect from next GAIN/MIX; both asserted same cycle loads both; reset gain = 1<<gain_shift (unity).
REQ-014 pipe_enable SHALL be sampled each WAIT/MIX cycle; mid-frame change affects only remaining lanes.

Reset
REQ-015 reset low SHALL asynchronously force IDLE, ready=1, out_valid=0, pipe_tick=0, out_frame=0, pipe_sample=0, pipe_lane=0, counters=0, timeout_err=0, gains unity; mid-frame reset discards frame, no out_valid.

Structure
REQ-016 Shared package SHALL hold state encodings, unity-gain constant and saturate function.
REQ-017 One sub-module, gain_sat_mul (signed multiply, shift, saturate), SHALL be instantiated for both gains.

Verification
REQ-018 Unity gains, 2 enabled pipelines returning 0x0100 and 0x0200 at SETTLE+1, frame {0x0010,0x0020} -> out_frame both lanes 0x0300, out_valid 11 cycles after sample_ready.
REQ-019 input_gain 0x0040 (x2), lane sample 0x7000 -> pipe_sample 0x7FFF; sum 0x7FFF+0x7FFF -> output 0x7FFF saturated; negatives -> 0x8000.
REQ-020 pipe_ready[1] stuck low, enable 2'b11 -> timeout_err=1, timeout_count=1, that lane 0x0000, sequence completes; enable 2'b01 same stimulus -> no timeout.
REQ-021 sample_ready pulsed in WAIT three times -> overrun_count=3, current frame unaffected.
REQ-022 reset low during WAIT lane 1 -> immediate IDLE, no out_valid, counters 0; next frame normal.
REQ-023 frame_count preset via 2^32-1 frames (forced) -> wraps to 0 on next OUTPUT.
